// File: rtl/monitor_report_collector.sv
// Report collector for a monitor automaton. Each non-zero report vector is tagged with
// the index of the symbol that triggered it and queued for the aggregation logic.
module monitor_report_collector #(
   parameter int NUM_REPORTS = 4,
   parameter int IDX_WIDTH   = 16,
   parameter int FIFO_DEPTH  = 8,
   parameter int DROP_WIDTH  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic [NUM_REPORTS-1:0] report_in,
   output logic                   rpt_valid,
   input  logic                   rpt_ready,
   output logic [IDX_WIDTH-1:0]   rpt_index,
   output logic [NUM_REPORTS-1:0] rpt_vector,
   output logic                   overflow,
   output logic [DROP_WIDTH-1:0]  drop_count,
   input  logic                   clear_overflow,
   output logic                   any_report
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic                   run_d;
   logic [IDX_WIDTH-1:0]   sym_idx;
   logic [IDX_WIDTH-1:0]   idx_d;
   logic [AW:0]            wr_ptr;
   logic [AW:0]            rd_ptr;
   logic [IDX_WIDTH-1:0]   idx_mem [FIFO_DEPTH];
   logic [NUM_REPORTS-1:0] vec_mem [FIFO_DEPTH];

   logic empty;
   logic full;
   logic push;
   logic pop;
   logic accept;
   logic drop;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      empty  = (wr_ptr == rd_ptr);
      full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      push   = run_d && (report_in != '0);
      pop    = !empty && rpt_ready;
      accept = push && (!full || pop);
      drop   = push && full && !pop;
   end

   assign rpt_valid  = !empty;
   assign rpt_index  = empty ? '0 : idx_mem[rd_ptr[AW-1:0]];
   assign rpt_vector = empty ? '0 : vec_mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!reset && accept) begin
         idx_mem[wr_ptr[AW-1:0]] <= idx_d;
         vec_mem[wr_ptr[AW-1:0]] <= report_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_d      <= 1'b0;
         sym_idx    <= '0;
         idx_d      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
         any_report <= 1'b0;
      end else begin
         run_d <= run;
         idx_d <= sym_idx;
         if (run) begin
            sym_idx <= sym_idx + 1'b1;
         end
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (run_d) begin
            any_report <= |report_in;
         end
         // A drop in the same cycle as a clear leaves exactly one drop recorded.
         if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
               drop_count <= DROP_WIDTH'(1);
            end else if (drop_count != '1) begin
               drop_count <= drop_count + 1'b1;
            end
         end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_monitor_report_collector.sv
// Bench for monitor_report_collector: directed scenarios and a random run, checked
// against a queue-based model of tagged records, drop accounting and symbol numbering.
module tb_monitor_report_collector;

   localparam int NR    = 4;
   localparam int IW    = 4;
   localparam int DEPTH = 8;
   localparam int DW    = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          run = 1'b0;
   logic [NR-1:0] report_in = '0;
   logic          rpt_ready = 1'b0;
   logic          clear_overflow = 1'b0;
   logic          rpt_valid;
   logic [IW-1:0] rpt_index;
   logic [NR-1:0] rpt_vector;
   logic          overflow;
   logic [DW-1:0] drop_count;
   logic          any_report;

   monitor_report_collector #(
      .NUM_REPORTS(NR),
      .IDX_WIDTH  (IW),
      .FIFO_DEPTH (DEPTH),
      .DROP_WIDTH (DW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .run           (run),
      .report_in     (report_in),
      .rpt_valid     (rpt_valid),
      .rpt_ready     (rpt_ready),
      .rpt_index     (rpt_index),
      .rpt_vector    (rpt_vector),
      .overflow      (overflow),
      .drop_count    (drop_count),
      .clear_overflow(clear_overflow),
      .any_report    (any_report)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int vec;
   } rec_t;

   rec_t q[$];
   int   m_sym;
   int   m_idx_d;
   bit   m_run_d;
   bit   m_over;
   int   m_drops;
   bit   m_any;
   int   n_checks = 0;
   int   n_fail = 0;

   function automatic logic [NR-1:0] nz();
      return NR'($urandom_range(1, (1 << NR) - 1));
   endfunction

   task automatic checkValue(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // The record queue holds what software should see, in arrival order.
   task automatic modelStep();
      bit valid, pop, push, dropped;
      if (reset) begin
         q.delete();
         m_sym = 0; m_idx_d = 0; m_run_d = 0; m_over = 0; m_drops = 0; m_any = 0;
      end else begin
         valid   = (q.size() > 0);
         pop     = valid && rpt_ready;
         push    = m_run_d && (report_in != 0);
         dropped = push && (q.size() == DEPTH) && !pop;
         if (pop) void'(q.pop_front());
         if (push && !dropped) q.push_back('{idx: m_idx_d, vec: int'(report_in)});
         if (clear_overflow) begin
            m_over = 0; m_drops = 0;
         end
         if (dropped) begin
            m_over = 1;
            m_drops = (m_drops + 1 > (1 << DW) - 1) ? (1 << DW) - 1 : m_drops + 1;
         end
         if (m_run_d) m_any = (report_in != 0);
         m_idx_d = m_sym;
         m_run_d = run;
         if (run) m_sym = (m_sym + 1) % (1 << IW);
      end
   endtask

   task automatic checkOutput();
      bit v;
      v = (q.size() > 0);
      checkValue("rpt_valid", int'(rpt_valid), int'(v));
      checkValue("rpt_index", int'(rpt_index), v ? q[0].idx : 0);
      checkValue("rpt_vector", int'(rpt_vector), v ? q[0].vec : 0);
      checkValue("overflow", int'(overflow), int'(m_over));
      checkValue("drop_count", int'(drop_count), m_drops);
      checkValue("any_report", int'(any_report), int'(m_any));
   endtask

   task automatic applyStimulus(input logic r_run, input logic [NR-1:0] r_rep,
                                input logic r_ready, input logic r_clr, input logic r_rst);
      run = r_run; report_in = r_rep; rpt_ready = r_ready;
      clear_overflow = r_clr; reset = r_rst;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput();
   endtask

   initial begin
      // Reset state
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      checkValue("reset_valid", int'(rpt_valid), 0);
      checkValue("reset_drops", int'(drop_count), 0);

      // Single report on symbol 2
      for (int k = 0; k < 5; k++) applyStimulus(1, (k == 3) ? 4'b0100 : 4'b0000, 0, 0, 0);
      checkValue("single_idx", int'(rpt_index), 2);
      checkValue("single_vec", int'(rpt_vector), 4);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      checkValue("single_popped", int'(rpt_valid), 0);

      // Backpressure and overflow
      applyStimulus(0, 0, 0, 0, 1);
      for (int k = 0; k < 11; k++) applyStimulus(k < 10, nz(), 0, 0, 0);
      checkValue("bp_overflow", int'(overflow), 1);
      checkValue("bp_drops", int'(drop_count), 2);
      for (int k = 0; k < 3; k++) applyStimulus(0, nz(), 0, 0, 0);
      checkValue("bp_stall_idx", int'(rpt_index), 0);
      for (int i = 0; i < 8; i++) begin
         checkValue("bp_drain_idx", int'(rpt_index), i);
         applyStimulus(0, 0, 1, 0, 0);
      end
      checkValue("bp_empty", int'(rpt_valid), 0);

      // Full with simultaneous pop
      applyStimulus(0, 0, 0, 0, 1);
      for (int k = 0; k < 9; k++) applyStimulus(1, nz(), 0, 0, 0);
      for (int k = 0; k < 10; k++) applyStimulus(1, nz(), 1, 0, 0);
      checkValue("fullpop_drops", int'(drop_count), 0);

      // Gaps in run
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(1, nz(), 0, 0, 0);
      applyStimulus(0, nz(), 0, 0, 0);
      applyStimulus(1, nz(), 0, 0, 0);
      applyStimulus(1, nz(), 0, 0, 0);
      applyStimulus(0, nz(), 0, 0, 0);
      applyStimulus(0, nz(), 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checkValue("gap_idx", int'(rpt_index), i);
         applyStimulus(0, 0, 1, 0, 0);
      end
      checkValue("gap_empty", int'(rpt_valid), 0);

      // Index wrap
      applyStimulus(0, 0, 1, 0, 1);
      for (int k = 0; k < 18; k++) begin
         applyStimulus(1, (k >= 16) ? nz() : 4'b0000, 1, 0, 0);
         if (k == 16) checkValue("wrap_idx15", int'(rpt_index), 15);
         if (k == 17) checkValue("wrap_idx0", int'(rpt_index), 0);
      end
      applyStimulus(0, 0, 1, 0, 0);

      // Drop counter saturation and clear
      applyStimulus(0, 0, 0, 0, 1);
      for (int k = 0; k < 15; k++) applyStimulus(1, nz(), 0, 0, 0);
      checkValue("sat_drops", int'(drop_count), 3);
      applyStimulus(0, 0, 0, 1, 0);
      checkValue("clr_overflow", int'(overflow), 0);
      checkValue("clr_drops", int'(drop_count), 0);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, nz(), 0, 1, 0);
      checkValue("clrdrop_overflow", int'(overflow), 1);
      checkValue("clrdrop_drops", int'(drop_count), 1);

      // Reset mid-stream
      applyStimulus(0, 0, 0, 0, 1);
      for (int k = 0; k < 4; k++) applyStimulus(1, nz(), 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, nz(), 0, 0, 1);
      checkValue("midrst_valid", int'(rpt_valid), 0);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, nz(), 0, 0, 0);
      checkValue("midrst_idx", int'(rpt_index), 0);
      checkValue("midrst_valid2", int'(rpt_valid), 1);

      // Random traffic
      for (int k = 0; k < 600; k++) begin
         applyStimulus($urandom_range(0, 3) != 0,
                       ($urandom_range(0, 1) != 0) ? nz() : 4'b0000,
                       $urandom_range(0, 4) > 1,
                       $urandom_range(0, 19) == 0,
                       $urandom_range(0, 49) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
